// File: rtl/adsr_envelope_pkg.sv
// Shared definitions for the ADSR envelope block: stage encodings and default sample depth.
package adsr_envelope_pkg;

    localparam int unsigned WAVE_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        STAGE_IDLE    = 3'd0,
        STAGE_ATTACK  = 3'd1,
        STAGE_DECAY   = 3'd2,
        STAGE_SUSTAIN = 3'd3,
        STAGE_RELEASE = 3'd4
    } stage_e;

endpackage

// File: rtl/adsr_envelope_env_scaler.sv
// Registered amplitude scaler: WaveIn * Envelope >> WAVE_DEPTH, with full-scale pass-through.
module env_scaler
    import adsr_envelope_pkg::*;
#(
    parameter int unsigned WAVE_DEPTH = WAVE_DEPTH_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WAVE_DEPTH-1:0] WaveIn,
    input  logic [WAVE_DEPTH-1:0] Envelope,
    output logic [WAVE_DEPTH-1:0] WaveOut
);

    logic [2*WAVE_DEPTH-1:0] prod;
    logic [WAVE_DEPTH-1:0]   wave_d;
    logic [WAVE_DEPTH-1:0]   wave_q;

    assign prod = (2*WAVE_DEPTH)'(WaveIn) * (2*WAVE_DEPTH)'(Envelope);

    // Full-scale envelope passes the sample through so 0xFF stays 0xFF rather than 0xFE.
    always_comb begin
        wave_d = prod[2*WAVE_DEPTH-1:WAVE_DEPTH];
        if (Envelope == '1) begin
            wave_d = WaveIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wave_q <= '0;
        end else begin
            wave_q <= wave_d;
        end
    end

    assign WaveOut = wave_q;

endmodule

// File: rtl/adsr_envelope.sv
// Gated ADSR envelope generator: prescaler, gate edge detect, stage FSM and
// fixed-point accumulator, followed by a registered amplitude scaler.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int unsigned WAVE_DEPTH = WAVE_DEPTH_DEF,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned RATE_WIDTH = 8,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Gate,
    input  logic [RATE_WIDTH-1:0] AttackRate,
    input  logic [RATE_WIDTH-1:0] DecayRate,
    input  logic [WAVE_DEPTH-1:0] SustainLevel,
    input  logic [RATE_WIDTH-1:0] ReleaseRate,
    input  logic [WAVE_DEPTH-1:0] WaveIn,
    output logic [WAVE_DEPTH-1:0] WaveOut,
    output logic [WAVE_DEPTH-1:0] Envelope,
    output logic [2:0]            Stage,
    output logic                  Active
);

    localparam int unsigned ACC_W = WAVE_DEPTH + FRAC_BITS;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {{WAVE_DEPTH{1'b1}}, {FRAC_BITS{1'b0}}};

    stage_e             stage_q, stage_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;
    logic               gate_q;
    logic               armed_q;

    logic               tick;
    logic               rise;
    logic               fall;
    logic [ACC_W-1:0]   target;
    logic [ACC_W:0]     acc_ext;
    logic [ACC_W:0]     sum_atk;
    logic [ACC_W:0]     dif_dec;
    logic [ACC_W:0]     dif_rel;

    assign tick = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // armed_q suppresses edge detection on the first clock after reset so a
    // Gate held high across reset release is absorbed without a rise.
    assign rise = armed_q &  Gate & ~gate_q;
    assign fall = armed_q & ~Gate &  gate_q;

    assign target  = {SustainLevel, {FRAC_BITS{1'b0}}};
    assign acc_ext = {1'b0, acc_q};
    assign sum_atk = acc_ext + (ACC_W+1)'(AttackRate);
    assign dif_dec = acc_ext - (ACC_W+1)'(DecayRate);
    assign dif_rel = acc_ext - (ACC_W+1)'(ReleaseRate);

    always_comb begin
        stage_d = stage_q;
        acc_d   = acc_q;
        unique case (stage_q)
            STAGE_IDLE: begin
                acc_d = '0;
                if (rise) begin
                    stage_d = STAGE_ATTACK;
                end
            end
            STAGE_ATTACK: begin
                if (fall) begin
                    stage_d = STAGE_RELEASE;
                end else if (tick) begin
                    if (AttackRate == '0 || sum_atk >= {1'b0, ACC_MAX}) begin
                        acc_d   = ACC_MAX;
                        stage_d = STAGE_DECAY;
                    end else begin
                        acc_d = sum_atk[ACC_W-1:0];
                    end
                end
            end
            STAGE_DECAY: begin
                if (fall) begin
                    stage_d = STAGE_RELEASE;
                end else if (tick) begin
                    if (DecayRate == '0 || dif_dec[ACC_W] || dif_dec[ACC_W-1:0] <= target) begin
                        acc_d   = target;
                        stage_d = STAGE_SUSTAIN;
                    end else begin
                        acc_d = dif_dec[ACC_W-1:0];
                    end
                end
            end
            STAGE_SUSTAIN: begin
                if (fall) begin
                    stage_d = STAGE_RELEASE;
                end else begin
                    acc_d = target;
                end
            end
            STAGE_RELEASE: begin
                if (rise) begin
                    stage_d = STAGE_ATTACK;
                end else if (tick) begin
                    if (ReleaseRate == '0 || dif_rel[ACC_W] || dif_rel[ACC_W-1:0] == '0) begin
                        acc_d   = '0;
                        stage_d = STAGE_IDLE;
                    end else begin
                        acc_d = dif_rel[ACC_W-1:0];
                    end
                end
            end
            default: begin
                acc_d   = '0;
                stage_d = STAGE_IDLE;
            end
        endcase
        active_d = (stage_d != STAGE_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stage_q  <= STAGE_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            gate_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            gate_q   <= Gate;
            armed_q  <= 1'b1;
        end
    end

    assign Envelope = acc_q[ACC_W-1 -: WAVE_DEPTH];
    assign Stage    = stage_q;
    assign Active   = active_q;

    env_scaler #(
        .WAVE_DEPTH(WAVE_DEPTH)
    ) u_scaler (
        .Clock    (Clock),
        .Reset    (Reset),
        .WaveIn   (WaveIn),
        .Envelope (Envelope),
        .WaveOut  (WaveOut)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus randomized run against a behavioural model.
module tb_adsr_envelope;

    logic       Clock;
    logic       Reset;
    logic       Gate;
    logic [7:0] AttackRate, DecayRate, SustainLevel, ReleaseRate, WaveIn;
    logic [7:0] WaveOut, Envelope;
    logic [2:0] Stage;
    logic       Active;

    logic       Gate4;
    logic [7:0] AttackRate4, DecayRate4, SustainLevel4, ReleaseRate4, WaveIn4;
    logic [7:0] WaveOut4, Envelope4;
    logic [2:0] Stage4;
    logic       Active4;

    int pass_cnt = 0;
    int total_cnt = 0;

    adsr_envelope #(
        .WAVE_DEPTH(8), .FRAC_BITS(8), .RATE_WIDTH(8), .TICK_DIV(1)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Gate(Gate),
        .AttackRate(AttackRate), .DecayRate(DecayRate), .SustainLevel(SustainLevel),
        .ReleaseRate(ReleaseRate), .WaveIn(WaveIn), .WaveOut(WaveOut),
        .Envelope(Envelope), .Stage(Stage), .Active(Active)
    );

    adsr_envelope #(
        .WAVE_DEPTH(8), .FRAC_BITS(8), .RATE_WIDTH(8), .TICK_DIV(4)
    ) dut4 (
        .Clock(Clock), .Reset(Reset), .Gate(Gate4),
        .AttackRate(AttackRate4), .DecayRate(DecayRate4), .SustainLevel(SustainLevel4),
        .ReleaseRate(ReleaseRate4), .WaveIn(WaveIn4), .WaveOut(WaveOut4),
        .Envelope(Envelope4), .Stage(Stage4), .Active(Active4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model of the TICK_DIV=1 instance: acc as a plain integer in 1/256 units.
    localparam int MAXACC = 65280;
    int m_acc = 0;
    int m_stage = 0;
    int m_wave = 0;
    bit m_gprev = 0;
    bit m_armed = 0;

    initial begin
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                m_acc = 0; m_stage = 0; m_wave = 0; m_gprev = 0; m_armed = 0;
            end else begin
                int env, t, nxt;
                bit rise, fall;
                env = m_acc / 256;
                m_wave = (env == 255) ? int'(WaveIn) : (int'(WaveIn) * env) / 256;
                rise = m_armed && Gate && !m_gprev;
                fall = m_armed && !Gate && m_gprev;
                t = int'(SustainLevel) * 256;
                if (m_stage == 0) begin
                    m_acc = 0;
                    if (rise) m_stage = 1;
                end else if (fall && m_stage != 4) begin
                    m_stage = 4;
                end else if (rise && m_stage == 4) begin
                    m_stage = 1;
                end else begin
                    case (m_stage)
                        1: begin
                            nxt = m_acc + int'(AttackRate);
                            m_acc = (AttackRate == 0 || nxt > MAXACC) ? MAXACC : nxt;
                            if (m_acc == MAXACC) m_stage = 2;
                        end
                        2: begin
                            nxt = m_acc - int'(DecayRate);
                            m_acc = (DecayRate == 0 || nxt < t) ? t : nxt;
                            if (m_acc == t) m_stage = 3;
                        end
                        3: m_acc = t;
                        default: begin
                            nxt = m_acc - int'(ReleaseRate);
                            m_acc = (ReleaseRate == 0 || nxt < 0) ? 0 : nxt;
                            if (m_acc == 0) m_stage = 0;
                        end
                    endcase
                end
                m_gprev = Gate;
                m_armed = 1;
            end
        end
    end

    task automatic test_reset;
        Reset = 1'b0; Gate = 1'b1; WaveIn = 8'hFF;
        AttackRate = 8'h80; DecayRate = 8'h40; SustainLevel = 8'h80; ReleaseRate = 8'h80;
        Gate4 = 1'b0; AttackRate4 = 8'h00; DecayRate4 = 8'h00; SustainLevel4 = 8'h60;
        ReleaseRate4 = 8'h00; WaveIn4 = 8'hFF;
        repeat (3) @(negedge Clock);
        total_cnt++; if (WaveOut !== 8'h00) $display("FAIL reset_waveout got %h want 00", WaveOut); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'h00) $display("FAIL reset_envelope got %h want 00", Envelope); else pass_cnt++;
        total_cnt++; if (Stage !== 3'd0) $display("FAIL reset_stage got %0d want 0", Stage); else pass_cnt++;
        total_cnt++; if (Active !== 1'b0) $display("FAIL reset_active got %b want 0", Active); else pass_cnt++;
        Reset = 1'b1;
        repeat (8) begin
            @(negedge Clock);
            total_cnt++; if (Stage !== 3'd0) $display("FAIL gate_held_stage got %0d want 0", Stage); else pass_cnt++;
        end
        total_cnt++; if (Envelope !== 8'h00) $display("FAIL gate_held_envelope got %h want 00", Envelope); else pass_cnt++;
    endtask

    task automatic test_attack;
        int n;
        Gate = 1'b0;
        @(negedge Clock);
        Gate = 1'b1;
        @(negedge Clock);
        total_cnt++; if (Stage !== 3'd1) $display("FAIL attack_enter got %0d want 1", Stage); else pass_cnt++;
        total_cnt++; if (Active !== 1'b1) $display("FAIL attack_active got %b want 1", Active); else pass_cnt++;
        n = 0;
        while (Stage == 3'd1 && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        total_cnt++; if (n !== 510) $display("FAIL attack_ticks got %0d want 510", n); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'hFF) $display("FAIL attack_peak got %h want ff", Envelope); else pass_cnt++;
        total_cnt++; if (Stage !== 3'd2) $display("FAIL attack_to_decay got %0d want 2", Stage); else pass_cnt++;
    endtask

    task automatic test_decay;
        int n;
        n = 0;
        while (Stage == 3'd2 && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        total_cnt++; if (n !== 508) $display("FAIL decay_ticks got %0d want 508", n); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'h80) $display("FAIL decay_level got %h want 80", Envelope); else pass_cnt++;
        total_cnt++; if (Stage !== 3'd3) $display("FAIL decay_to_sustain got %0d want 3", Stage); else pass_cnt++;
        @(negedge Clock);
        total_cnt++; if (WaveOut !== 8'h7F) $display("FAIL sustain_waveout got %h want 7f", WaveOut); else pass_cnt++;
    endtask

    task automatic test_sustain_follow;
        logic [7:0] sl, wi, exp;
        for (int i = 0; i < 16; i++) begin
            sl = (i == 3) ? 8'hFF : ((i == 5) ? 8'h00 : 8'($urandom_range(0, 255)));
            wi = 8'($urandom_range(0, 255));
            SustainLevel = sl; WaveIn = wi;
            @(negedge Clock);
            total_cnt++; if (Envelope !== sl) $display("FAIL sustain_follow got %h want %h", Envelope, sl); else pass_cnt++;
            @(negedge Clock);
            exp = (sl == 8'hFF) ? wi : 8'((int'(wi) * int'(sl)) / 256);
            total_cnt++; if (WaveOut !== exp) $display("FAIL sustain_scale got %h want %h", WaveOut, exp); else pass_cnt++;
        end
        total_cnt++; if (Stage !== 3'd3) $display("FAIL sustain_stay got %0d want 3", Stage); else pass_cnt++;
        SustainLevel = 8'h80; WaveIn = 8'hFF;
        @(negedge Clock);
    endtask

    task automatic test_release;
        int n;
        Gate = 1'b0;
        @(negedge Clock);
        total_cnt++; if (Stage !== 3'd4) $display("FAIL release_enter got %0d want 4", Stage); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'h80) $display("FAIL release_start got %h want 80", Envelope); else pass_cnt++;
        n = 0;
        while (Stage == 3'd4 && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        total_cnt++; if (n !== 256) $display("FAIL release_ticks got %0d want 256", n); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'h00) $display("FAIL release_floor got %h want 00", Envelope); else pass_cnt++;
        total_cnt++; if (Stage !== 3'd0) $display("FAIL release_idle got %0d want 0", Stage); else pass_cnt++;
        total_cnt++; if (Active !== 1'b0) $display("FAIL release_active got %b want 0", Active); else pass_cnt++;
        @(negedge Clock);
        total_cnt++; if (WaveOut !== 8'h00) $display("FAIL release_waveout got %h want 00", WaveOut); else pass_cnt++;
    endtask

    task automatic test_retrigger;
        int n;
        bit ok;
        AttackRate = 8'h00; DecayRate = 8'h00; SustainLevel = 8'h80;
        Gate = 1'b1;
        n = 0;
        do begin @(negedge Clock); n++; end while (Stage != 3'd3 && n < 20);
        ReleaseRate = 8'h10; Gate = 1'b0;
        n = 0;
        do begin @(negedge Clock); n++; end while (Envelope != 8'h40 && n < 3000);
        total_cnt++; if (Envelope !== 8'h40) $display("FAIL retrig_reach got %h want 40", Envelope); else pass_cnt++;
        AttackRate = 8'h04; Gate = 1'b1;
        @(negedge Clock);
        total_cnt++; if (Stage !== 3'd1) $display("FAIL retrig_stage got %0d want 1", Stage); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'h40) $display("FAIL retrig_hold got %h want 40", Envelope); else pass_cnt++;
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (Envelope < 8'h40) ok = 1'b0;
        end
        total_cnt++; if (ok !== 1'b1) $display("FAIL retrig_no_dip got %b want 1", ok); else pass_cnt++;
        total_cnt++; if (Envelope !== 8'(m_acc / 256)) $display("FAIL retrig_env got %h want %h", Envelope, 8'(m_acc / 256)); else pass_cnt++;
        total_cnt++; if (Envelope <= 8'h40) $display("FAIL retrig_rising got %h want above 40", Envelope); else pass_cnt++;
    endtask

    task automatic test_random;
        int hold;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                AttackRate   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8, 255));
                DecayRate    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8, 255));
                ReleaseRate  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8, 255));
                SustainLevel = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            end
            if (hold == 0) begin
                Gate = ~Gate;
                hold = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 400));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 15) == 0) SustainLevel = 8'($urandom_range(0, 255));
            WaveIn = 8'($urandom_range(0, 255));
            @(negedge Clock);
            total_cnt++; if (Envelope !== 8'(m_acc / 256)) $display("FAIL rand_env c=%0d got %h want %h", c, Envelope, 8'(m_acc / 256)); else pass_cnt++;
            total_cnt++; if (Stage !== 3'(m_stage)) $display("FAIL rand_stage c=%0d got %0d want %0d", c, Stage, m_stage); else pass_cnt++;
            total_cnt++; if (Active !== (m_stage != 0)) $display("FAIL rand_active c=%0d got %b want %b", c, Active, m_stage != 0); else pass_cnt++;
            total_cnt++; if (WaveOut !== 8'(m_wave)) $display("FAIL rand_wave c=%0d got %h want %h", c, WaveOut, 8'(m_wave)); else pass_cnt++;
        end
    endtask

    task automatic test_tickdiv4;
        int n, m;
        Gate4 = 1'b1;
        n = 0;
        do begin @(negedge Clock); n++; end while (Envelope4 != 8'hFF && n < 12);
        total_cnt++; if (!(n >= 2 && n <= 5)) $display("FAIL div4_attack clocks got %0d want 2..5", n); else pass_cnt++;
        total_cnt++; if (Stage4 !== 3'd2) $display("FAIL div4_decay_stage got %0d want 2", Stage4); else pass_cnt++;
        m = 0;
        do begin @(negedge Clock); m++; end while (Envelope4 != 8'h60 && m < 12);
        total_cnt++; if (m !== 4) $display("FAIL div4_decay clocks got %0d want 4", m); else pass_cnt++;
        total_cnt++; if (Stage4 !== 3'd3) $display("FAIL div4_sustain got %0d want 3", Stage4); else pass_cnt++;
        Gate4 = 1'b0;
    endtask

    task automatic test_reset_midnote;
        Gate = 1'b0; AttackRate = 8'h10;
        @(negedge Clock);
        Gate = 1'b1;
        repeat (50) @(negedge Clock);
        total_cnt++; if (Envelope !== 8'(m_acc / 256)) $display("FAIL midnote_env got %h want %h", Envelope, 8'(m_acc / 256)); else pass_cnt++;
        #2 Reset = 1'b0;
        #1;
        total_cnt++; if (Envelope !== 8'h00) $display("FAIL async_env got %h want 00", Envelope); else pass_cnt++;
        total_cnt++; if (Stage !== 3'd0) $display("FAIL async_stage got %0d want 0", Stage); else pass_cnt++;
        total_cnt++; if (Active !== 1'b0) $display("FAIL async_active got %b want 0", Active); else pass_cnt++;
        total_cnt++; if (WaveOut !== 8'h00) $display("FAIL async_wave got %h want 00", WaveOut); else pass_cnt++;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        total_cnt++; if (Stage !== 3'd0) $display("FAIL rearm_stage got %0d want 0", Stage); else pass_cnt++;
        Gate = 1'b0;
        @(negedge Clock);
        Gate = 1'b1;
        @(negedge Clock);
        total_cnt++; if (Stage !== 3'd1) $display("FAIL rearm_attack got %0d want 1", Stage); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_sustain_follow();
        test_release();
        test_retrigger();
        test_random();
        test_tickdiv4();
        test_reset_midnote();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
